// File: rtl/kbd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kbd_pkg : shared constants and decoder state type for kbd_scan_fifo |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package kbd_pkg;

  localparam logic [7:0] KBD_BRK       = 8'hF0;
  localparam logic [7:0] KBD_EXT0      = 8'hE0;
  localparam logic [7:0] KBD_EXT1      = 8'hE1;
  localparam logic [7:0] KBD_F7_S2     = 8'h83;
  localparam logic [7:0] KBD_F7_S1     = 8'h41;
  localparam logic [7:0] KBD_BREAK_BIT = 8'h80;

  typedef enum logic [0:0] {
    NORM = 1'b0,
    BRK  = 1'b1
  } kbd_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_xlat_rom.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_xlat_rom : combinational 128x8 AT set-2 to XT set-1 code table  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ps2_xlat_rom (
  input  logic [6:0] addr,
  output logic [7:0] data
);

  // Codes with no set-1 equivalent read back as 00.
  always_comb begin
    data = 8'h00;
    case (addr)
      7'h01: data = 8'h43;  7'h03: data = 8'h3F;  7'h04: data = 8'h3D;  7'h05: data = 8'h3B;
      7'h06: data = 8'h3C;  7'h07: data = 8'h58;  7'h09: data = 8'h44;  7'h0A: data = 8'h42;
      7'h0B: data = 8'h40;  7'h0C: data = 8'h3E;  7'h0D: data = 8'h0F;  7'h0E: data = 8'h29;
      7'h11: data = 8'h38;  7'h12: data = 8'h2A;  7'h14: data = 8'h1D;  7'h15: data = 8'h10;
      7'h16: data = 8'h02;  7'h1A: data = 8'h2C;  7'h1B: data = 8'h1F;  7'h1C: data = 8'h1E;
      7'h1D: data = 8'h11;  7'h1E: data = 8'h03;  7'h21: data = 8'h2E;  7'h22: data = 8'h2D;
      7'h23: data = 8'h20;  7'h24: data = 8'h12;  7'h25: data = 8'h05;  7'h26: data = 8'h04;
      7'h29: data = 8'h39;  7'h2A: data = 8'h2F;  7'h2B: data = 8'h21;  7'h2C: data = 8'h14;
      7'h2D: data = 8'h13;  7'h2E: data = 8'h06;  7'h31: data = 8'h31;  7'h32: data = 8'h30;
      7'h33: data = 8'h23;  7'h34: data = 8'h22;  7'h35: data = 8'h15;  7'h36: data = 8'h07;
      7'h3A: data = 8'h32;  7'h3B: data = 8'h24;  7'h3C: data = 8'h16;  7'h3D: data = 8'h08;
      7'h3E: data = 8'h09;  7'h41: data = 8'h33;  7'h42: data = 8'h25;  7'h43: data = 8'h17;
      7'h44: data = 8'h18;  7'h45: data = 8'h0B;  7'h46: data = 8'h0A;  7'h49: data = 8'h34;
      7'h4A: data = 8'h35;  7'h4B: data = 8'h26;  7'h4C: data = 8'h27;  7'h4D: data = 8'h19;
      7'h4E: data = 8'h0C;  7'h52: data = 8'h28;  7'h54: data = 8'h1A;  7'h55: data = 8'h0D;
      7'h58: data = 8'h3A;  7'h59: data = 8'h36;  7'h5A: data = 8'h1C;  7'h5B: data = 8'h1B;
      7'h5D: data = 8'h2B;  7'h66: data = 8'h0E;  7'h69: data = 8'h4F;  7'h6B: data = 8'h4B;
      7'h6C: data = 8'h47;  7'h70: data = 8'h52;  7'h71: data = 8'h53;  7'h72: data = 8'h50;
      7'h73: data = 8'h4C;  7'h74: data = 8'h4D;  7'h75: data = 8'h48;  7'h76: data = 8'h01;
      7'h77: data = 8'h45;  7'h78: data = 8'h57;  7'h79: data = 8'h4E;  7'h7A: data = 8'h51;
      7'h7B: data = 8'h4A;  7'h7C: data = 8'h37;  7'h7D: data = 8'h49;  7'h7E: data = 8'h46;
      default: data = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/kbd_scan_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kbd_scan_fifo : PS/2 scancode decoder + FIFO feeding port 60h/IRQ1  |
// | Build macro KBD_XLAT_EN enables set-2 -> set-1 translation.          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module kbd_scan_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_hit,
  input  logic        rd,
  input  logic        ovf_clr,
  output logic [7:0]  q,
  output logic        ready,
  output logic [AW:0] count,
  output logic        overflow,
  output logic        irq_req
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_en;
  logic [7:0]    push_byte;

`ifdef KBD_XLAT_EN
  kbd_state_t state;
  logic [7:0] xlat;
  logic [7:0] base;
  logic       is_key;

  ps2_xlat_rom u_rom (
    .addr (ps2_data[6:0]),
    .data (xlat)
  );

  // Only translatable key codes (00..7F and the F7 oddity 83) take the break bit.
  always_comb begin
    is_key    = !ps2_data[7] || (ps2_data == KBD_F7_S2);
    base      = !ps2_data[7] ? xlat :
                (ps2_data == KBD_F7_S2) ? KBD_F7_S1 : ps2_data;
    push_en   = ps2_hit && (ps2_data != KBD_BRK);
    push_byte = ((state == BRK) && is_key) ? (base | KBD_BREAK_BIT) : base;
  end

  // Any F0 (from either state) arms the break prefix; every other byte consumes it.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= NORM;
    end else if (ps2_hit) begin
      state <= (ps2_data == KBD_BRK) ? BRK : NORM;
    end
  end
`else
  assign push_en   = ps2_hit;
  assign push_byte = ps2_data;
`endif

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  // DEPTH is a power of two, so count reaches DEPTH exactly when its MSB sets.
  always_comb begin
    empty   = (count == '0);
    full    = count[AW];
    do_pop  = rd && !empty;
    do_push = push_en && (!full || do_pop);
    drop    = push_en && full && !do_pop;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // When full, a simultaneous push lands in the slot being popped; q reads it pre-edge.
  always_ff @(posedge clock) begin
    if (resetn && do_push) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  assign q       = mem[rd_ptr];
  assign ready   = !empty;
  assign irq_req = !empty;

endmodule
`default_nettype wire
